// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port between fetch (F) and loader (L).
// A lock holds a stalled selection; an owner FIFO routes in-order read responses back.
module imem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         f_req,
    input  logic [ADDR_W-1:0]            f_addr,
    output logic                         f_gnt,
    output logic                         f_rvalid,
    output logic [DATA_W-1:0]            f_rdata,
    input  logic                         l_req,
    input  logic                         l_we,
    input  logic [ADDR_W-1:0]            l_addr,
    input  logic [DATA_W-1:0]            l_wdata,
    output logic                         l_gnt,
    output logic                         l_rvalid,
    output logic [DATA_W-1:0]            l_rdata,
    output logic                         m_req,
    output logic                         m_we,
    output logic [ADDR_W-1:0]            m_addr,
    output logic [DATA_W-1:0]            m_wdata,
    input  logic                         m_gnt,
    input  logic                         m_rvalid,
    input  logic [DATA_W-1:0]            m_rdata,
    output logic [$clog2(MAX_OUTST):0]   outst_cnt,
    output logic                         err_spurious
);

    localparam int PTR_W = $clog2(MAX_OUTST);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {OWN_F = 1'b0, OWN_L = 1'b1} owner_e;

    logic             lock_q, lock_d;
    owner_e           lock_own_q, lock_own_d;
    owner_e           last_win_q, last_win_d;
    owner_e           fifo_q [MAX_OUTST];
    owner_e           fifo_d [MAX_OUTST];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    owner_e sel_own_s;
    logic   sel_vld_s, sel_we_s, issue_block_s, accept_s, push_s, pop_s;
    owner_e head_s;

    // Requester selection: a held lock overrides round-robin.
    always_comb begin
        sel_own_s = OWN_F;
        sel_vld_s = 1'b0;
        if (lock_q) begin
            sel_own_s = lock_own_q;
            sel_vld_s = (lock_own_q == OWN_L) ? l_req : f_req;
        end else if (f_req && l_req) begin
            sel_own_s = (last_win_q == OWN_L) ? OWN_F : OWN_L;
            sel_vld_s = 1'b1;
        end else if (l_req) begin
            sel_own_s = OWN_L;
            sel_vld_s = 1'b1;
        end else if (f_req) begin
            sel_own_s = OWN_F;
            sel_vld_s = 1'b1;
        end else begin
            sel_vld_s = 1'b0;
        end
    end

    // Only reads occupy an owner slot, so only reads can be throttled.
    assign sel_we_s      = (sel_own_s == OWN_L) && l_we;
    assign issue_block_s = (cnt_q == CNT_W'(MAX_OUTST)) && !sel_we_s;
    assign m_req         = sel_vld_s && !issue_block_s && !reset;
    assign m_we          = m_req && sel_we_s;
    assign m_addr        = !m_req ? {ADDR_W{1'b0}} : ((sel_own_s == OWN_L) ? l_addr : f_addr);
    assign m_wdata       = (m_req && (sel_own_s == OWN_L)) ? l_wdata : {DATA_W{1'b0}};
    assign accept_s      = m_req && m_gnt;
    assign f_gnt         = accept_s && (sel_own_s == OWN_F);
    assign l_gnt         = accept_s && (sel_own_s == OWN_L);
    assign push_s        = accept_s && !sel_we_s;

    assign head_s   = fifo_q[rd_ptr_q];
    assign pop_s    = m_rvalid && (cnt_q != CNT_W'(0)) && !reset;
    assign f_rvalid = pop_s && (head_s == OWN_F);
    assign l_rvalid = pop_s && (head_s == OWN_L);
    assign f_rdata  = reset ? {DATA_W{1'b0}} : m_rdata;
    assign l_rdata  = reset ? {DATA_W{1'b0}} : m_rdata;

    assign outst_cnt    = cnt_q;
    assign err_spurious = err_q;

    // Next-state for lock, round-robin pointer, owner FIFO and error flag.
    always_comb begin
        lock_d     = lock_q;
        lock_own_d = lock_own_q;
        last_win_d = last_win_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        err_d      = m_rvalid && (cnt_q == CNT_W'(0));
        if (accept_s) begin
            lock_d     = 1'b0;
            last_win_d = sel_own_s;
        end else if (m_req) begin
            lock_d     = 1'b1;
            lock_own_d = sel_own_s;
        end else begin
            lock_d = lock_q;
        end
        if (push_s) begin
            fifo_d[wr_ptr_q] = sel_own_s;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; last winner resets to L so F wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q     <= 1'b0;
            lock_own_q <= OWN_F;
            last_win_q <= OWN_L;
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            err_q      <= 1'b0;
            for (int i = 0; i < MAX_OUTST; i++) begin
                fifo_q[i] <= OWN_F;
            end
        end else begin
            lock_q     <= lock_d;
            lock_own_q <= lock_own_d;
            last_win_q <= last_win_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single instruction-memory port between two requesters: the fetch stage (port F, read-only) and the program loader/debug port (port L, read/write).
- Round-robin arbitration with a request lock that holds the selection until the memory accepts it.
- Tracks in-flight reads in an owner FIFO so in-order read responses are routed back to the issuing requester.
- Sits between fetch/loader and the instruction memory wrapper.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_OUTST, 4, maximum in-flight reads (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
f_req  in  1  fetch read request; held with f_addr stable until f_gnt
f_addr  in  ADDR_W  fetch address
f_gnt  out  1  fetch request accepted this cycle
f_rvalid  out  1  fetch read data valid
f_rdata  out  DATA_W  fetch read data
l_req  in  1  loader request; held with l_we/l_addr/l_wdata stable until l_gnt
l_we  in  1  loader write enable
l_addr  in  ADDR_W  loader address
l_wdata  in  DATA_W  loader write data
l_gnt  out  1  loader request accepted this cycle
l_rvalid  out  1  loader read data valid
l_rdata  out  DATA_W  loader read data
m_req  out  1  memory request
m_we  out  1  memory write enable
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_gnt  in  1  memory accepts m_req this cycle
m_rvalid  in  1  memory read response valid, in issue order, >=1 cycle after accept
m_rdata  in  DATA_W  memory read data
outst_cnt  out  $clog2(MAX_OUTST)+1  in-flight read count
err_spurious  out  1  one-cycle pulse: m_rvalid with empty owner FIFO

Behaviour:
- Reset (async, while high):
  - lock, owner FIFO, count and err_spurious are cleared.
  - last_winner = L, so F wins the first tie.
  - All outputs are 0; m_req, f_gnt and l_gnt are forced to 0.
- Selection:
  - If lock is set, the locked owner drives m_*.
  - Otherwise, if only one requester is asserting req, that requester is selected.
  - If both are asserting req, the requester that is not last_winner is selected.
- m_req = selected req AND NOT issue_block.
  - issue_block = (registered count == MAX_OUTST) AND selected request is a read.
  - Writes are never blocked.
- m_we/m_addr/m_wdata are muxed from the selected requester (m_we=0 for F). They are 0 when m_req=0.
- Accept = m_req & m_gnt. It is combinational, same cycle: f_gnt/l_gnt = accept & owner.
- On accept:
  - last_winner <= owner; lock cleared.
  - If the request is a read, the owner ID is pushed to the FIFO and count increments.
  - Writes are not tracked and produce no response.
- Lock: if m_req=1 and m_gnt=0, lock <= selected owner. The selection and m_* are then frozen until accept, even if the other requester is asserting req.
- Stall under lock: if issue_block deasserts m_req while locked, the lock persists.
- Response routing (combinational):
  - On m_rvalid with a non-empty FIFO, head = owner.
  - {f,l}_rvalid = m_rvalid & (head==F/L); the FIFO pops and count decrements.
  - f_rdata and l_rdata both = m_rdata, unqualified.
- Same-cycle accept-read and response: push and pop together; count is unchanged.
- FIFO full with a pop in the same cycle: issue is still blocked that cycle, because issue_block uses the registered count.
- m_rvalid with an empty FIFO:
  - No rvalid is routed and nothing is popped.
  - err_spurious is registered 1 for the next cycle.
  - Covers responses from requests issued before a mid-operation reset.
- A requester dropping req before gnt is a protocol violation; behaviour is undefined except that lock clears on reset.
- Latency:
  - Grant: 0 cycles after m_gnt.
  - Response: memory latency + 0.

Test Plan:
- Only f_req=1, f_addr=0x100, m_gnt=1; m_rvalid 2 cycles later with m_rdata=0xDEADBEEF -> f_gnt=1 in cycle 0; f_rvalid=1, f_rdata=0xDEADBEEF in cycle 2; l_rvalid=0; outst_cnt 1 then 0.
- f_req and l_req held continuously, m_gnt=1, loader reads -> grants alternate F,L,F,L starting with F after reset. Responses in order route F,L,F,L.
- Both requesting, m_gnt=0 for 3 cycles with F selected, then l_req only... F still held -> m_addr stays f_addr for all 3 cycles; F granted on the first m_gnt=1; L is granted after.
- Fetch reads with m_rvalid withheld until 4 are outstanding -> m_req=0 on the 5th read; outst_cnt=4. A loader write (l_we=1, 0x200, 0x55) is still issued and granted. Read issue resumes the cycle after the first m_rvalid.
- Assert reset with 2 reads in flight; release; drive m_rvalid twice -> no f/l_rvalid; err_spurious pulses one cycle after each; outst_cnt=0.
- Read accepted in the same cycle as the response of the previous read -> outst_cnt unchanged. The next response routes to the correct owner.
